unidade_busca: RTL
==================

UNIDADE_BUSCA -- requirements
Module: unidade_busca

Interface
REQ-001 The block SHALL have parameter LARGURA_END, default 8, giving the program address width in bits.
REQ-002 The block SHALL have parameter ENDERECO_INICIAL, default 0, giving the PC value after reset.
REQ-003 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-004 The block SHALL have these ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- habilita  in  1  run enable
- rom_end  out  LARGURA_END  address to the synchronous program ROM
- rom_dado  in  16  ROM read data, valid one cycle after rom_end is sampled
- instr_done  in  1  single-cycle pulse from the processor: current instruction finished
- desvio  in  1  branch request, qualified by instr_done
- alvo_desvio  in  LARGURA_END  branch target address
- iin  out  16  instruction word to the processor's iin input
- iin_valido  out  1  iin holds a fetched, not-yet-completed instruction
- pc  out  LARGURA_END  address of the instruction in iin / being fetched
- parado  out  1  halt instruction reached
- contagem_instr  out  16  completed-instruction count

Function
REQ-005 The state machine SHALL have the states OCIOSO, BUSCA, LEITURA, EXECUTA and PARADO.
REQ-006 rom_end SHALL equal pc combinationally in every state.
REQ-007 OCIOSO: habilita=1 SHALL go to BUSCA; otherwise the block SHALL stay in OCIOSO.
REQ-008 BUSCA SHALL last exactly one cycle, during which the ROM samples rom_end; the next state SHALL be LEITURA.
REQ-009 LEITURA SHALL last exactly one cycle and SHALL register rom_dado into iin at the end of the cycle.
- If rom_dado=16'hFFFF, the next state SHALL be PARADO.
- Otherwise, the next state SHALL be EXECUTA.
REQ-010 iin_valido SHALL be 1 only in EXECUTA; first assertion occurs 2 cycles after BUSCA is entered.
REQ-011 iin SHALL remain stable for the whole time in EXECUTA.
REQ-012 EXECUTA with instr_done=1 SHALL update pc at the same edge:
- desvio=1: pc <= alvo_desvio
- desvio=0: pc <= pc+1 modulo 2^LARGURA_END, so the maximum address wraps to 0
REQ-013 At that same edge, contagem_instr SHALL increment, saturating at 16'hFFFF.
REQ-014 At that same edge, the next state SHALL be BUSCA if habilita=1 and OCIOSO otherwise.
REQ-015 Without instr_done, the block SHALL remain in EXECUTA indefinitely; habilita is ignored there.
REQ-016 instr_done, desvio and alvo_desvio SHALL be ignored in every state except EXECUTA.
REQ-017 habilita=0 SHALL NOT abort BUSCA or LEITURA; it takes effect only in OCIOSO or at instruction completion.
REQ-018 PARADO SHALL hold parado=1, iin_valido=0, and freeze pc, iin and contagem_instr; only reset SHALL leave it.
REQ-019 The halt word SHALL NOT be counted in contagem_instr.
REQ-020 In PARADO, pc SHALL hold the address of the halt word.

Reset
REQ-021 When reset=1 is sampled, reset SHALL override all other inputs in every state, including mid-fetch and EXECUTA.
REQ-022 Reset SHALL set: state=OCIOSO, pc=ENDERECO_INICIAL, iin=16'h0000, iin_valido=0, parado=0, contagem_instr=0.
REQ-023 A ROM word in flight at reset SHALL be discarded.
REQ-024 Outputs SHALL be defined from the first edge with reset=1.

Verification
REQ-025 Sequential fetch: ROM[0]=16'h1234, ROM[1]=16'h5678, habilita=1, done pulsed 3 cycles after each iin_valido -> iin_valido after 2 cycles with iin=16'h1234 and pc=0; then pc=1 and iin=16'h5678; contagem_instr=2.
REQ-026 Branch: in EXECUTA at pc=3, instr_done=1, desvio=1, alvo_desvio=8'h40 -> next edge pc=8'h40; fetch of ROM[8'h40] appears on iin 2 cycles later.
REQ-027 Wrap and spurious done:
- pc=8'hFF, done with desvio=0 -> pc=8'h00
- instr_done pulsed in BUSCA/LEITURA -> no pc or count change
REQ-028 Halt: ROM[2]=16'hFFFF after two normal words -> parado=1, iin_valido=0, pc=2, contagem_instr=2, stable for 20 cycles despite done/habilita toggling.
REQ-029 Pause: habilita dropped during LEITURA -> instruction still presented; after done, state OCIOSO, iin_valido=0, pc advanced; re-raising habilita resumes the fetch at the new pc.
REQ-030 Reset mid-operation: reset=1 during EXECUTA with contagem_instr=5 -> next edge pc=ENDERECO_INICIAL, iin=0, iin_valido=0, contagem_instr=0, state OCIOSO.

Source files
------------

// File: rtl/unidade_busca.sv
// unidade_busca: instruction fetch unit in front of a synchronous program ROM.
//
// The unit presents pc on rom_end, waits one cycle for the ROM to sample it
// (BUSCA), registers the returned word into iin (LEITURA), then holds that
// word with iin_valido=1 until the processor pulses instr_done (EXECUTA).
// A returned word of 16'hFFFF is the halt instruction: the unit parks in
// PARADO until reset.
//
// Ports:
//   clock          in   sole clock, rising edge
//   reset          in   synchronous, active-high reset
//   habilita       in   run enable (checked in OCIOSO and at instruction completion)
//   rom_end        out  ROM address, always equal to pc
//   rom_dado       in   ROM read data, valid one cycle after rom_end is sampled
//   instr_done     in   one-cycle pulse: current instruction finished
//   desvio         in   branch request, qualified by instr_done
//   alvo_desvio    in   branch target address
//   iin            out  fetched instruction word
//   iin_valido     out  iin holds a fetched, not-yet-completed instruction
//   pc             out  address of the instruction in iin / being fetched
//   parado         out  halt instruction reached
//   contagem_instr out  completed-instruction count, saturating

module unidade_busca #(
  parameter int unsigned                 LARGURA_END      = 8,
  parameter logic [LARGURA_END-1:0]      ENDERECO_INICIAL = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   habilita,
  output logic [LARGURA_END-1:0] rom_end,
  input  logic [15:0]            rom_dado,
  input  logic                   instr_done,
  input  logic                   desvio,
  input  logic [LARGURA_END-1:0] alvo_desvio,
  output logic [15:0]            iin,
  output logic                   iin_valido,
  output logic [LARGURA_END-1:0] pc,
  output logic                   parado,
  output logic [15:0]            contagem_instr
);

  localparam logic [15:0] PalavraParada = 16'hFFFF;

  typedef enum logic [2:0] {
    StOcioso,
    StBusca,
    StLeitura,
    StExecuta,
    StParado
  } estado_t;

  estado_t estado;

  // The ROM registers its address itself, so the address is pc directly.
  assign rom_end = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      // Any word the ROM returns after this edge lands in BUSCA/OCIOSO and is dropped.
      estado         <= StOcioso;
      pc             <= ENDERECO_INICIAL;
      iin            <= 16'h0000;
      iin_valido     <= 1'b0;
      parado         <= 1'b0;
      contagem_instr <= 16'h0000;
    end else begin
      unique case (estado)
        StOcioso: begin
          if (habilita) begin
            estado <= StBusca;
          end
        end

        // ROM samples rom_end at the end of this cycle; habilita cannot abort.
        StBusca: begin
          estado <= StLeitura;
        end

        StLeitura: begin
          iin <= rom_dado;
          if (rom_dado == PalavraParada) begin
            // pc is left pointing at the halt word and the count is not bumped.
            estado <= StParado;
            parado <= 1'b1;
          end else begin
            estado     <= StExecuta;
            iin_valido <= 1'b1;
          end
        end

        StExecuta: begin
          if (instr_done) begin
            if (desvio) begin
              pc <= alvo_desvio;
            end else begin
              pc <= pc + 1'b1;  // wraps naturally at 2^LARGURA_END
            end
            if (contagem_instr != 16'hFFFF) begin
              contagem_instr <= contagem_instr + 16'd1;
            end
            iin_valido <= 1'b0;
            estado     <= habilita ? StBusca : StOcioso;
          end
        end

        StParado: begin
          // Frozen until reset.
        end

        default: begin
          estado <= StOcioso;
        end
      endcase
    end
  end

endmodule
